// File: rtl/dram_axi_slave.sv
// ---------------------------------------------------------------------------
// dram_axi_slave
//   AXI4-lite responder in front of a DEPTH x 64-bit memory. One transaction
//   is in flight at a time; every response appears a fixed LAT cycles after
//   its data-bearing handshake (AR for reads, W for writes).
//
// Parameters
//   DEPTH  number of 64-bit words (word index = ADDR[15:3] mod DEPTH)
//   LAT    1..15, cycles from AR / W handshake to R_VALID / B_VALID
//
// Configuration macro
//   ADDR_CHECK_EN  when defined, an address is OKAY only if ADDR[16]=1,
//                  ADDR[2:0]=0 and ADDR[15:3]<DEPTH; any other address gets
//                  SLVERR, no memory write and R_DATA=0 (timing unchanged).
//                  When undefined every response is OKAY.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   AR_VALID/AR_ADDR/AR_READY       read address channel
//   R_VALID/R_DATA/R_RESP/R_READY   read data channel
//   AW_VALID/AW_ADDR/AW_READY       write address channel
//   W_VALID/W_DATA/W_READY          write data channel
//   B_VALID/B_RESP/B_READY          write response channel
//   dbg_state                       current FSM state (debug)
//
// Handshake rule: a transfer happens in a cycle where VALID and READY are
// both 1 at the rising edge. READY outputs here are registered, so AR_READY /
// AW_READY rise one cycle after the matching VALID is seen in IDLE and stay
// high for exactly one cycle; the master is expected to hold VALID and the
// address until then. Responses hold VALID and payload until READY is seen.
// Memory contents are not reset.
// ---------------------------------------------------------------------------
module dram_axi_slave #(
  parameter int DEPTH = 256,
  parameter int LAT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  output logic [1:0]  R_RESP,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  output logic [1:0]  B_RESP,
  input  logic        B_READY,
  output logic [2:0]  dbg_state
);

  localparam int         IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_R_WAIT = 3'd1,
    ST_R_RESP = 3'd2,
    ST_W_DATA = 3'd3,
    ST_W_WAIT = 3'd4,
    ST_B_RESP = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] addr_q, addr_d;

  logic        ar_ready_d, r_valid_d, aw_ready_d, w_ready_d, b_valid_d;
  logic [63:0] r_data_d;
  logic [1:0]  r_resp_d, b_resp_d;
  logic        mem_we;

  logic [63:0] mem [DEPTH];

  function automatic logic [IW-1:0] word_idx(input logic [16:0] a);
    return IW'(32'(a[15:3]) % DEPTH);
  endfunction

  // In the AR handshake cycle the address is still on the bus (needed when
  // LAT=1 produces data at that same edge); afterwards the captured copy is
  // used, which also covers the write path.
  logic [16:0] chk_addr;
  logic        chk_ok;
  logic [63:0] rd_word;
  logic [1:0]  resp_code;

  assign chk_addr = (state_q == ST_R_WAIT && AR_READY) ? AR_ADDR : addr_q;

`ifdef ADDR_CHECK_EN
  assign chk_ok = chk_addr[16] && (chk_addr[2:0] == 3'b000) &&
                  (32'(chk_addr[15:3]) < DEPTH);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{chk_addr[16], chk_addr[2:0]};
  assign chk_ok = 1'b1;
`endif

  assign rd_word   = chk_ok ? mem[word_idx(chk_addr)] : 64'd0;
  assign resp_code = chk_ok ? 2'b00 : 2'b10;

  // State register plus the registered outputs and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 17'd0;
      AR_READY <= 1'b0;
      R_VALID  <= 1'b0;
      R_DATA   <= 64'd0;
      R_RESP   <= 2'b00;
      AW_READY <= 1'b0;
      W_READY  <= 1'b0;
      B_VALID  <= 1'b0;
      B_RESP   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      AR_READY <= ar_ready_d;
      R_VALID  <= r_valid_d;
      R_DATA   <= r_data_d;
      R_RESP   <= r_resp_d;
      AW_READY <= aw_ready_d;
      W_READY  <= w_ready_d;
      B_VALID  <= b_valid_d;
      B_RESP   <= b_resp_d;
    end
  end

  // Memory has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx(addr_q)] <= W_DATA;
  end

  // Next-state logic. Read wins over write in IDLE; VALIDs are ignored in
  // every other state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (AR_VALID)      state_d = ST_R_WAIT;
        else if (AW_VALID) state_d = ST_W_DATA;
      end
      ST_R_WAIT: begin
        if (AR_READY) begin
          if (LAT == 1) state_d = ST_R_RESP;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_R_RESP;
        end
      end
      ST_R_RESP: if (R_READY) state_d = ST_IDLE;
      ST_W_DATA: begin
        if (!AW_READY && W_READY && W_VALID)
          state_d = (LAT == 1) ? ST_B_RESP : ST_W_WAIT;
      end
      ST_W_WAIT: if (cnt_q <= 4'd1) state_d = ST_B_RESP;
      ST_B_RESP: if (B_READY) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic. The counter is loaded with LAT-1 at the
  // handshake edge; the response is raised on the edge leaving count 1, so it
  // is visible exactly LAT cycles after the handshake cycle.
  always_comb begin
    ar_ready_d = AR_READY;
    r_valid_d  = R_VALID;
    r_data_d   = R_DATA;
    r_resp_d   = R_RESP;
    aw_ready_d = AW_READY;
    w_ready_d  = W_READY;
    b_valid_d  = B_VALID;
    b_resp_d   = B_RESP;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (AR_VALID)      ar_ready_d = 1'b1;
        else if (AW_VALID) aw_ready_d = 1'b1;
      end
      ST_R_WAIT: begin
        if (AR_READY) begin
          ar_ready_d = 1'b0;
          addr_d     = AR_ADDR;
          cnt_d      = LAT_M1;
          if (LAT == 1) begin
            r_valid_d = 1'b1;
            r_data_d  = rd_word;
            r_resp_d  = resp_code;
          end
        end else begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            r_valid_d = 1'b1;
            r_data_d  = rd_word;
            r_resp_d  = resp_code;
          end
        end
      end
      ST_R_RESP: begin
        if (R_READY) begin
          r_valid_d = 1'b0;
          r_data_d  = 64'd0;
          r_resp_d  = 2'b00;
        end
      end
      ST_W_DATA: begin
        if (AW_READY) begin
          aw_ready_d = 1'b0;
          addr_d     = AW_ADDR;
          w_ready_d  = 1'b1;
        end else if (W_READY && W_VALID) begin
          w_ready_d = 1'b0;
          mem_we    = chk_ok;
          cnt_d     = LAT_M1;
          if (LAT == 1) begin
            b_valid_d = 1'b1;
            b_resp_d  = resp_code;
          end
        end
      end
      ST_W_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          b_valid_d = 1'b1;
          b_resp_d  = resp_code;
        end
      end
      ST_B_RESP: begin
        if (B_READY) begin
          b_valid_d = 1'b0;
          b_resp_d  = 2'b00;
        end
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dram_axi_slave.sv
// ---------------------------------------------------------------------------
// tb_dram_axi_slave
//   Directed bench for dram_axi_slave. Two instances share clk/rst_n: u_dut
//   with default parameters (DEPTH=256, LAT=4) and u_l1 with LAT=1. Inputs
//   change 1 ns after the rising edge; outputs are sampled at that same point,
//   so every check sees the values registered by the preceding edge.
// ---------------------------------------------------------------------------
module tb_dram_axi_slave;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [16:0] ar_addr, aw_addr;
  logic [63:0] r_data, w_data;
  logic [1:0]  r_resp, b_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [2:0]  state;

  // LAT=1 instance
  logic        l_ar_valid, l_ar_ready, l_r_valid, l_r_ready;
  logic [16:0] l_ar_addr, l_aw_addr;
  logic [63:0] l_r_data, l_w_data;
  logic [1:0]  l_r_resp, l_b_resp;
  logic        l_aw_valid, l_aw_ready, l_w_valid, l_w_ready, l_b_valid, l_b_ready;
  logic [2:0]  l_state;

  dram_axi_slave u_dut (
    .clk(clk), .rst_n(rst_n),
    .AR_VALID(ar_valid), .AR_ADDR(ar_addr), .AR_READY(ar_ready),
    .R_VALID(r_valid), .R_DATA(r_data), .R_RESP(r_resp), .R_READY(r_ready),
    .AW_VALID(aw_valid), .AW_ADDR(aw_addr), .AW_READY(aw_ready),
    .W_VALID(w_valid), .W_DATA(w_data), .W_READY(w_ready),
    .B_VALID(b_valid), .B_RESP(b_resp), .B_READY(b_ready),
    .dbg_state(state)
  );

  dram_axi_slave #(.DEPTH(256), .LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .AR_VALID(l_ar_valid), .AR_ADDR(l_ar_addr), .AR_READY(l_ar_ready),
    .R_VALID(l_r_valid), .R_DATA(l_r_data), .R_RESP(l_r_resp), .R_READY(l_r_ready),
    .AW_VALID(l_aw_valid), .AW_ADDR(l_aw_addr), .AW_READY(l_aw_ready),
    .W_VALID(l_w_valid), .W_DATA(l_w_data), .W_READY(l_w_ready),
    .B_VALID(l_b_valid), .B_RESP(l_b_resp), .B_READY(l_b_ready),
    .dbg_state(l_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_R_WAIT = 3'd1;
  localparam logic [2:0] S_W_DATA = 3'd3;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered in the AR handshake cycle (AR_READY already checked high).
  // R_VALID must appear 4 cycles later and stay stable while R_READY=0.
  task automatic read_from_hs(input logic [63:0] exp_data, input logic [1:0] exp_resp,
                              input int hold);
    tick;
    ar_valid = 1'b0;
    check("ar_ready_one_cycle", {63'd0, ar_ready}, 64'd0);
    check("r_wait_state", {61'd0, state}, {61'd0, S_R_WAIT});
    for (int j = 1; j < 4; j++) begin
      check("r_valid_early", {63'd0, r_valid}, 64'd0);
      check("r_data_idle_zero", r_data, 64'd0);
      tick;
    end
    check("r_valid_at_lat", {63'd0, r_valid}, 64'd1);
    check("r_data", r_data, exp_data);
    check("r_resp", {62'd0, r_resp}, {62'd0, exp_resp});
    for (int i = 0; i < hold; i++) begin
      tick;
      check("r_valid_held", {63'd0, r_valid}, 64'd1);
      check("r_data_held", r_data, exp_data);
      check("r_resp_held", {62'd0, r_resp}, {62'd0, exp_resp});
    end
    r_ready = 1'b1;
    tick;
    r_ready = 1'b0;
    check("r_valid_drop", {63'd0, r_valid}, 64'd0);
    check("r_data_drop", r_data, 64'd0);
    check("r_idle_after", {61'd0, state}, {61'd0, S_IDLE});
  endtask

  task automatic do_read(input logic [16:0] addr, input logic [63:0] exp_data,
                         input logic [1:0] exp_resp, input int hold);
    ar_valid = 1'b1;
    ar_addr  = addr;
    tick;
    check("ar_ready", {63'd0, ar_ready}, 64'd1);
    read_from_hs(exp_data, exp_resp, hold);
  endtask

  // Entered in the AW handshake cycle. B_VALID must appear 4 cycles after
  // the W handshake cycle.
  task automatic write_from_hs(input logic [63:0] data, input logic [1:0] exp_resp);
    tick;
    aw_valid = 1'b0;
    check("aw_ready_one_cycle", {63'd0, aw_ready}, 64'd0);
    check("w_ready_high", {63'd0, w_ready}, 64'd1);
    w_valid = 1'b1;
    w_data  = data;
    tick;
    w_valid = 1'b0;
    check("w_ready_drop", {63'd0, w_ready}, 64'd0);
    for (int j = 1; j < 4; j++) begin
      check("b_valid_early", {63'd0, b_valid}, 64'd0);
      tick;
    end
    check("b_valid_at_lat", {63'd0, b_valid}, 64'd1);
    check("b_resp", {62'd0, b_resp}, {62'd0, exp_resp});
    b_ready = 1'b1;
    tick;
    b_ready = 1'b0;
    check("b_valid_drop", {63'd0, b_valid}, 64'd0);
    check("w_idle_after", {61'd0, state}, {61'd0, S_IDLE});
  endtask

  task automatic do_write(input logic [16:0] addr, input logic [63:0] data,
                          input logic [1:0] exp_resp);
    aw_valid = 1'b1;
    aw_addr  = addr;
    tick;
    check("aw_ready", {63'd0, aw_ready}, 64'd1);
    check("w_data_state", {61'd0, state}, {61'd0, S_W_DATA});
    write_from_hs(data, exp_resp);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {55'd0, ar_ready, r_valid, r_resp, aw_ready, w_ready, b_valid, b_resp},
          64'd0);
    check({tag, "_rdata"}, r_data, 64'd0);
    check({tag, "_state"}, {61'd0, state}, {61'd0, S_IDLE});
  endtask

  localparam logic [63:0] D_A = 64'hDEADBEEF_01234567;
  localparam logic [63:0] D_B = 64'h01234567_89ABCDEF;
  localparam logic [63:0] D_C = 64'hA5A5A5A5_5A5A5A5A;
  localparam logic [63:0] D_D = 64'h00000000_CAFEF00D;
  localparam logic [63:0] D_E = 64'h13579BDF_2468ACE0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] l1_d [2];
    l1_d[0] = 64'h11112222_33334444;
    l1_d[1] = 64'h55556666_77778888;

    rst_n = 1'b0;
    ar_valid = 1'b0; ar_addr = '0; r_ready = 1'b0;
    aw_valid = 1'b0; aw_addr = '0; w_valid = 1'b0; w_data = '0; b_ready = 1'b0;
    l_ar_valid = 1'b0; l_ar_addr = '0; l_r_ready = 1'b0;
    l_aw_valid = 1'b0; l_aw_addr = '0; l_w_valid = 1'b0; l_w_data = '0; l_b_ready = 1'b0;
    repeat (3) tick;
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    tick;
    check_all_zero("after_reset_idle");

    // Write then read back, no backpressure
    do_write(17'h10008, D_A, 2'b00);
    do_read(17'h10008, D_A, 2'b00, 0);

    // R backpressure for 6 cycles
    do_write(17'h10010, D_B, 2'b00);
    do_read(17'h10010, D_B, 2'b00, 6);

`ifdef ADDR_CHECK_EN
    // Out-of-window write is refused and leaves memory intact
    do_write(17'h00008, D_E, 2'b10);
    do_read(17'h10008, D_A, 2'b00, 0);
    do_read(17'h10004, 64'd0, 2'b10, 0);
    do_read(17'h00808, 64'd0, 2'b10, 0);
`else
    // Index is ADDR[15:3] mod 256: 0x00808 aliases word 1 (0x10008)
    do_read(17'h00808, D_A, 2'b00, 0);
    do_write(17'h00008, D_E, 2'b00);
    do_read(17'h10008, D_E, 2'b00, 0);
    do_write(17'h10008, D_A, 2'b00);
`endif

    // Simultaneous AR and AW: read first, write only after R handshake
    do_write(17'h10000, D_C, 2'b00);
    ar_valid = 1'b1; ar_addr = 17'h10000;
    aw_valid = 1'b1; aw_addr = 17'h10010;
    tick;
    check("both_ar_ready", {63'd0, ar_ready}, 64'd1);
    check("both_aw_ready_low", {63'd0, aw_ready}, 64'd0);
    read_from_hs(D_C, 2'b00, 0);
    check("aw_wait_after_r", {63'd0, aw_ready}, 64'd0);
    tick;
    check("aw_ready_after_r", {63'd0, aw_ready}, 64'd1);
    write_from_hs(D_D, 2'b00);
    do_read(17'h10010, D_D, 2'b00, 0);

    // Reset in R_WAIT discards the read; memory retained
    ar_valid = 1'b1; ar_addr = 17'h10008;
    tick;
    tick;
    ar_valid = 1'b0;
    tick;
    check("pre_reset_r_wait", {61'd0, state}, {61'd0, S_R_WAIT});
    rst_n = 1'b0;
    tick;
    check_all_zero("reset_mid_read");
    rst_n = 1'b1;
    tick;
    check_all_zero("reset_mid_read_release");
    do_read(17'h10008, D_A, 2'b00, 0);

    // Reset after the W handshake: data must already be in memory
    aw_valid = 1'b1; aw_addr = 17'h10018;
    tick;
    tick;
    aw_valid = 1'b0;
    w_valid = 1'b1; w_data = D_E;
    tick;
    w_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    check_all_zero("reset_mid_write");
    rst_n = 1'b1;
    tick;
    do_read(17'h10018, D_E, 2'b00, 0);

    // LAT=1 instance: writes, then back-to-back reads
    for (int i = 0; i < 2; i++) begin
      l_aw_valid = 1'b1;
      l_aw_addr  = 17'h10000 + 17'(i * 8);
      tick;
      check("l1_aw_ready", {63'd0, l_aw_ready}, 64'd1);
      tick;
      l_aw_valid = 1'b0;
      check("l1_w_ready", {63'd0, l_w_ready}, 64'd1);
      l_w_valid = 1'b1;
      l_w_data  = l1_d[i];
      tick;
      l_w_valid = 1'b0;
      check("l1_b_valid", {63'd0, l_b_valid}, 64'd1);
      check("l1_b_resp", {62'd0, l_b_resp}, 64'd0);
      l_b_ready = 1'b1;
      tick;
      l_b_ready = 1'b0;
      check("l1_b_drop", {63'd0, l_b_valid}, 64'd0);
    end
    l_r_ready = 1'b1;
    l_ar_valid = 1'b1; l_ar_addr = 17'h10000;
    tick;
    check("l1_ar_ready_0", {63'd0, l_ar_ready}, 64'd1);
    tick;
    check("l1_r_valid_0", {63'd0, l_r_valid}, 64'd1);
    check("l1_r_data_0", l_r_data, l1_d[0]);
    check("l1_ar_ready_drop_0", {63'd0, l_ar_ready}, 64'd0);
    l_ar_addr = 17'h10008;
    tick;
    check("l1_r_drop_0", {63'd0, l_r_valid}, 64'd0);
    check("l1_ar_gap", {63'd0, l_ar_ready}, 64'd0);
    tick;
    check("l1_ar_ready_1", {63'd0, l_ar_ready}, 64'd1);
    tick;
    l_ar_valid = 1'b0;
    check("l1_r_valid_1", {63'd0, l_r_valid}, 64'd1);
    check("l1_r_data_1", l_r_data, l1_d[1]);
    tick;
    l_r_ready = 1'b0;
    check("l1_r_drop_1", {63'd0, l_r_valid}, 64'd0);
    check("l1_idle", {61'd0, l_state}, {61'd0, S_IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
